mult_seq: RTL and testbench

Multi-cycle unsigned shift-add multiplier controller that sequences the existing shared 32-bit adder datapath. It owns no adder of its own. Each cycle it drives the two adder operands, reads back the sum, recovers the carry-out, and shifts the partial product. It sits beside the EX stage and serves a multiply request with a start/busy/done handshake.

---
 rtl/mult_seq.sv | 130 +++++++++++++
 tb/tb_mult_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq.sv
// Sequential unsigned shift-add multiplier that drives an external shared adder, one multiplier bit per cycle.
// Optional overflow flag output is enabled by defining MULT_OVF_EN.
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   add_in1,
  output logic [WIDTH-1:0]   add_in2,
  input  logic [WIDTH-1:0]   add_out,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
`ifdef MULT_OVF_EN
  ,
  output logic               ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               carry;
`ifdef MULT_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

`ifdef MULT_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    add_in1   = '0;
    add_in2   = '0;
    carry     = 1'b0;
`ifdef MULT_OVF_EN
    ovf_d     = ovf_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef MULT_OVF_EN
          ovf_d   = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        add_in1   = hi_q;
        add_in2   = lo_q[0] ? mcand_q : '0;
        // Carry-out of the shared adder rebuilt from operand and sum MSBs.
        carry     = (add_in1[WIDTH-1] & add_in2[WIDTH-1]) |
                    ((add_in1[WIDTH-1] ^ add_in2[WIDTH-1]) & ~add_out[WIDTH-1]);
        hi_d      = {carry, add_out[WIDTH-1:1]};
        lo_d      = {add_out[0], lo_q[WIDTH-1:1]};
        cnt_d     = cnt_q + CW'(1);
        product_d = {hi_d, lo_d};
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
`ifdef MULT_OVF_EN
          ovf_d   = |hi_d;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq with a behavioural adder and a queue of expected products.
module tb_mult_seq;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [W-1:0]   add_in1, add_in2, add_out;
  logic           busy, done;
  logic [2*W-1:0] product;
`ifdef MULT_OVF_EN
  logic           ovf;
`endif

  int total = 0;
  int bad = 0;
  logic [2*W-1:0] sb[$];

  assign add_out = add_in1 + add_in2;

  always #5 clk = ~clk;

  mult_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .add_in1 (add_in1),
    .add_in2 (add_in2),
    .add_out (add_out),
    .busy    (busy),
    .done    (done),
    .product (product)
`ifdef MULT_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if ((busy && done) !== 1'b0) begin
        bad++;
        $display("FAIL busy_done_overlap busy=%b done=%b", busy, done);
      end
    end
  end

  function automatic logic [2*W-1:0] pop_exp();
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  // Called just after a negedge; returns 1 ns after the accepting edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
    logic [2*W-1:0] pa, pb;
    pa = {{W{1'b0}}, ia};
    pb = {{W{1'b0}}, ib};
    a = ia;
    b = ib;
    start = 1'b1;
    sb.push_back(pa * pb);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_to_done(output int nbusy, output int at);
    nbusy = 0;
    at = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        at = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_flags busy=%b done=%b want 0 0", busy, done);
    end
    total++;
    if (product !== '0) begin
      bad++; $display("FAIL reset_product got=%h want=0", product);
    end
    total++;
    if (add_in1 !== '0 || add_in2 !== '0) begin
      bad++; $display("FAIL reset_operands in1=%h in2=%h want 0", add_in1, add_in2);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset busy=%b done=%b", busy, done);
    end
  endtask

  task automatic test_basic();
    int nb, at;
    logic [2*W-1:0] exp;
    @(negedge clk);
    issue(32'd3, 32'd5);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL basic_busy_rise got=%b want=1", busy);
    end
    run_to_done(nb, at);
    exp = pop_exp();
    total++;
    if (at !== W + 1) begin
      bad++; $display("FAIL basic_latency got=%0d want=%0d", at, W + 1);
    end
    total++;
    if (nb !== W) begin
      bad++; $display("FAIL basic_busy_cycles got=%0d want=%0d", nb, W);
    end
    total++;
    if (product !== exp) begin
      bad++; $display("FAIL basic_product got=%h want=%h", product, exp);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL basic_done_pulse got=%b want=0", done);
    end
  endtask

  task automatic test_carry();
    int mism, at;
    logic [W-1:0] ones;
    logic [2*W-1:0] exp;
    ones = '1;
    mism = 0;
    at = 0;
    @(negedge clk);
    issue(ones, ones);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (busy && add_in2 !== ones) mism++;
      if (done) begin
        at = i;
        break;
      end
    end
    exp = pop_exp();
    total++;
    if (mism !== 0) begin
      bad++; $display("FAIL carry_add_in2 mismatching_cycles=%0d want=0", mism);
    end
    total++;
    if (at !== W + 1) begin
      bad++; $display("FAIL carry_latency got=%0d want=%0d", at, W + 1);
    end
    total++;
    if (product !== exp) begin
      bad++; $display("FAIL carry_product got=%h want=%h", product, exp);
    end
    total++;
    if (add_in1 !== '0 || add_in2 !== '0) begin
      bad++; $display("FAIL operands_outside_run in1=%h in2=%h want 0", add_in1, add_in2);
    end
  endtask

  task automatic test_ignored_start();
    int at, extra;
    logic [2*W-1:0] exp;
    at = 0;
    extra = 0;
    @(negedge clk);
    issue(32'd2, 32'd3);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 10) begin
        start = 1'b1; a = 32'd7; b = 32'd7;
      end else if (i == 11) begin
        start = 1'b0;
      end
      if (done) begin
        at = i;
        break;
      end
    end
    exp = pop_exp();
    total++;
    if (at !== W + 1) begin
      bad++; $display("FAIL ignored_latency got=%0d want=%0d", at, W + 1);
    end
    total++;
    if (product !== exp) begin
      bad++; $display("FAIL ignored_product got=%h want=%h", product, exp);
    end
    repeat (5) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    total++;
    if (extra !== 0 || sb.size() !== 0) begin
      bad++; $display("FAIL ignored_no_extra_op active_cycles=%0d pending=%0d want 0 0", extra, sb.size());
    end
  endtask

  task automatic test_reset_midop();
    int nb, at, dseen;
    logic [2*W-1:0] exp;
    dseen = 0;
    @(negedge clk);
    issue(32'd9, 32'd9);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, product, add_in1, add_in2} !== '0) begin
      bad++; $display("FAIL midop_async_clear busy=%b done=%b product=%h in1=%h in2=%h want all 0",
                      busy, done, product, add_in1, add_in2);
    end
    sb.delete();
    repeat (3) begin
      @(negedge clk);
      if (done) dseen++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) dseen++;
    end
    total++;
    if (dseen !== 0) begin
      bad++; $display("FAIL midop_no_done active_cycles=%0d want=0", dseen);
    end
    issue(32'd4, 32'd4);
    run_to_done(nb, at);
    exp = pop_exp();
    total++;
    if (at !== W + 1 || product !== exp) begin
      bad++; $display("FAIL midop_recover latency=%0d product=%h want %0d %h", at, product, W + 1, exp);
    end
  endtask

  task automatic test_back_to_back();
    int nb, at;
    logic [2*W-1:0] exp1, exp2;
    @(negedge clk);
    a = 32'd10; b = 32'd10; start = 1'b1;
    sb.push_back(64'd100);
    @(posedge clk);
    #1 a = 32'h0001_0000; b = 32'h0001_0000;
    sb.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
    run_to_done(nb, at);
    exp1 = pop_exp();
    total++;
    if (at !== W + 1 || product !== exp1) begin
      bad++; $display("FAIL b2b_first latency=%0d product=%h want %0d %h", at, product, W + 1, exp1);
    end
    @(posedge clk);
    #1 start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || product !== exp1) begin
      bad++; $display("FAIL b2b_reaccept busy=%b done=%b product=%h want 1 0 %h", busy, done, product, exp1);
    end
    run_to_done(nb, at);
    exp2 = pop_exp();
    total++;
    if (at !== W + 1 || product !== exp2) begin
      bad++; $display("FAIL b2b_second latency=%0d product=%h want %0d %h", at, product, W + 1, exp2);
    end
  endtask

`ifdef MULT_OVF_EN
  task automatic test_ovf();
    int nb, at;
    logic [2*W-1:0] exp;
    @(negedge clk);
    issue(32'h0001_0000, 32'h0001_0000);
    run_to_done(nb, at);
    exp = pop_exp();
    total++;
    if (ovf !== (|exp[2*W-1:W]) || product !== exp) begin
      bad++; $display("FAIL ovf_set ovf=%b product=%h want %b %h", ovf, product, |exp[2*W-1:W], exp);
    end
    @(negedge clk);
    issue(32'h0000_FFFF, 32'h0000_FFFF);
    total++;
    if (ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_clear_on_start got=%b want=0", ovf);
    end
    run_to_done(nb, at);
    exp = pop_exp();
    total++;
    if (ovf !== (|exp[2*W-1:W]) || product !== exp) begin
      bad++; $display("FAIL ovf_fit ovf=%b product=%h want %b %h", ovf, product, |exp[2*W-1:W], exp);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignored_start();
    test_reset_midop();
    test_back_to_back();
`ifdef MULT_OVF_EN
    test_ovf();
`endif
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
